// File: rtl/addn_serial_pkg.sv
// Shared definitions for the addn_serial multi-cycle adder: FSM state
// encodings, default operand/chunk widths and a small sizing helper.
// Guarded so that repeated inclusion in one compilation unit is harmless.
`ifndef ADDN_SERIAL_PKG_SV
`define ADDN_SERIAL_PKG_SV

package addn_serial_pkg;

    // Default operand/result width in bits.
    localparam int DEF_WIDTH = 32'd16;

    // Default number of bits added per cycle.
    localparam int DEF_CHUNK = 32'd4;

    // Controller states: waiting, adding one slice per cycle, result ready.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } addn_state_e;

    // Number of slices needed to cover a word of the given width.
    function automatic int slice_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of a slice index able to address every slice (at least 1 bit).
    function automatic int index_width(input int nslice);
        if (nslice > 32'd1) begin
            return $clog2(nslice);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

`endif

// File: rtl/addn_serial_slice.sv
// Combinational ripple-carry building blocks for addn_serial:
//   full_adder_gate - one-bit full adder written as explicit gates
//   addn_slice      - CHUNK-bit ripple chain of full_adder_gate cells that
//                     also exposes the carry into its top bit, which the
//                     parent uses for two's-complement overflow detection.

module full_adder_gate (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic axb_s;
    logic ab_s;
    logic cx_s;

    assign axb_s = a ^ b;
    assign s     = axb_s ^ ci;
    assign ab_s  = a & b;
    assign cx_s  = axb_s & ci;
    assign co    = ab_s | cx_s;

endmodule

module addn_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    // c_s[k] is the carry into bit k; c_s[CHUNK] leaves the slice.
    logic [CHUNK:0] c_s;

    assign c_s[0] = cin;

    for (genvar k = 0; k < CHUNK; k++) begin : g_bit
        full_adder_gate u_fa (
            .a  (a[k]),
            .b  (b[k]),
            .ci (c_s[k]),
            .s  (sum[k]),
            .co (c_s[k+1])
        );
    end

    assign cout = c_s[CHUNK];
    assign cmsb = c_s[CHUNK-1];

endmodule

// File: rtl/addn_serial.sv
// addn_serial: WIDTH-bit adder that processes CHUNK bits per clock, LSB
// slice first, through a single shared addn_slice. A start in IDLE or DONE
// captures the operands; NSLICE busy cycles later out/cout/ovf are loaded
// together and done pulses for one cycle. Results only change on completion.
// Optional feature macro: ADDN_SUB_EN adds a 'sub' port selecting a - b.

module addn_serial
    import addn_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDN_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = slice_count(WIDTH, CHUNK);
    localparam int IDX_W  = index_width(NSLICE);

    // Controller state.
    addn_state_e state_r;
    addn_state_e state_s;
    logic        accept_s;
    logic        last_s;

    // Captured operands, shifted right one slice per busy cycle so the
    // slice being added is always at the bottom.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;

    // Partial sum, filled from the top as slices complete.
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_s;

    // Operand B and carry-in after optional subtract conditioning.
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    // Shared slice adder connections.
    logic [CHUNK-1:0] sum_s;
    logic             slice_cin_s;
    logic             slice_cout_s;
    logic             slice_cmsb_s;

`ifdef ADDN_SUB_EN
    // Subtract computes a + ~b + 1, so the external carry-in is ignored.
    always_comb begin
        if (sub) begin
            b_eff_s   = ~b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b;
            cin_eff_s = cin;
        end
    end
`else
    assign b_eff_s   = b;
    assign cin_eff_s = cin;
`endif

    // The first slice adds the captured carry-in, later slices chain the
    // carry produced by the previous slice.
    assign slice_cin_s = (idx_r == IDX_W'(0)) ? cin_r : carry_r;

    addn_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_r[CHUNK-1:0]),
        .b    (b_r[CHUNK-1:0]),
        .cin  (slice_cin_s),
        .sum  (sum_s),
        .cout (slice_cout_s),
        .cmsb (slice_cmsb_s)
    );

    // After NSLICE shifts the first slice has reached bit 0.
    if (NSLICE > 1) begin : g_acc_multi
        assign acc_s = {sum_s, acc_r[WIDTH-1:CHUNK]};
    end else begin : g_acc_single
        assign acc_s = sum_s;
    end

    // Next-state logic: accept work from IDLE or DONE, leave BUSY after the
    // final slice; start during BUSY has no effect.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (idx_r == IDX_W'(NSLICE - 1));
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = BUSY;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (start) begin
                    state_s  = BUSY;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register with registered busy/done flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == BUSY);
            done    <= (state_s == DONE);
        end
    end

    // Datapath: capture operands, add one slice per busy cycle, publish the
    // complete result only on the edge that finishes the last slice.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            cin_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            out     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b_eff_s;
            cin_r   <= cin_eff_s;
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else if (state_r == BUSY) begin
            a_r     <= a_r >> CHUNK;
            b_r     <= b_r >> CHUNK;
            acc_r   <= acc_s;
            carry_r <= slice_cout_s;
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) begin
                out  <= acc_s;
                cout <= slice_cout_s;
                ovf  <= slice_cout_s ^ slice_cmsb_s;
            end
        end
    end

endmodule

// File: doc/addn_serial.md
ADDN_SERIAL -- requirements
Module: addn_serial

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NSLICE = WIDTH/CHUNK.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new addition; operands sampled on the accepting edge.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 sub  input  1  subtract mode; present only with ADDN_SUB_EN.
REQ-010 busy  output  1  high while an operation is in progress (states BUSY).
REQ-011 done  output  1  one-cycle pulse when out/cout/ovf are updated.
REQ-012 out  output  WIDTH  registered sum.
REQ-013 cout  output  1  carry out of MSB.
REQ-014 ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE: start=1 -> capture a, b, cin (and sub), clear slice index, go BUSY; start=0 -> stay.
REQ-017 BUSY: each cycle add slice i (bits i*CHUNK+CHUNK-1 : i*CHUNK) of captured operands plus registered carry, store into internal accumulator, advance i, LSB slice first; slice 0 uses captured cin.
REQ-018 BUSY: after slice NSLICE-1 -> DONE, loading out, cout, ovf from accumulator/carries on that same edge.
REQ-019 Latency: start high in cycle 0 -> busy high cycles 1..NSLICE -> done high in cycle NSLICE+1 only (cycle 5 at defaults).
REQ-020 DONE: start=1 -> accept new operands, go BUSY (back-to-back, no idle bubble); start=0 -> IDLE.
REQ-021 start while BUSY SHALL be ignored; captured operands unchanged.
REQ-022 out, cout, ovf SHALL hold their last completed values until the next completion; never show partial sums.
REQ-023 Arithmetic modulo 2^WIDTH; cout = bit WIDTH of a+b+cin.

Reset
REQ-024 reset SHALL force IDLE, busy=0, done=0, out=0, cout=0, ovf=0, slice index and carry to 0; reset has priority over start.
REQ-025 Reset mid-operation SHALL abort it; no done for the aborted operation.

Configuration
REQ-026 With ADDN_SUB_EN defined: sub port exists; sub=1 computes a + ~b + 1 (cin ignored), cout=1 meaning no borrow, ovf = signed overflow of a-b.
REQ-027 Without ADDN_SUB_EN: no sub port; always a + b + cin.

Structure
REQ-028 Shared include header SHALL hold FSM state encodings (IDLE/BUSY/DONE) and default WIDTH/CHUNK constants, guarded against double inclusion.
REQ-029 One sub-module addn_slice SHALL implement the CHUNK-bit combinational ripple slice (a, b, cin -> sum, cout, carry into top bit) built from full_adder_gate instances.

Verification (WIDTH=16, CHUNK=4)
REQ-030 a=0x1234, b=0x4321, cin=0, start cycle 0 -> done cycle 5 only, out=0x5555, cout=0, ovf=0.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> out=0x0000, cout=1, ovf=0 (carry crosses all slices).
REQ-032 a=0x7FFF, b=0x0001 -> out=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> out=0x0000, cout=1, ovf=1.
REQ-033 start re-pulsed with a=b=0xAAAA in cycle 2 -> ignored, first result unchanged; start held in DONE cycle with a=0x0001, b=0x0002 -> second done 5 cycles later, out=0x0003.
REQ-034 reset asserted in cycle 3 of an operation -> next cycle busy=0, out=0, no done pulse afterwards.
REQ-035 ADDN_SUB_EN: a=0x0005, b=0x0007, sub=1, cin=1 -> out=0xFFFE, cout=0, ovf=0.
